// File: rtl/game_pkg.sv
// Shared definitions for the snake game: sequencer states, BCD digit type
// and the score ceiling agreed with the score tracker.
package game_pkg;

    // Encodings double as the debug LED pattern on state_out.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PLAY    = 2'b01,
        FLASH   = 2'b10,
        HISCORE = 2'b11
    } state_t;

    typedef logic [3:0] bcd_t;

    // Reaching this score raises trk_complete in the tracker (a win).
    localparam int MAX_SCORE = 50;

endpackage

// File: rtl/flash_timer.sv
// Flash phase timer: counts cycles within a half-period, counts half-periods,
// and toggles the blank flag at each half-period boundary. done pulses during
// the last cycle of the last half-period so the caller can leave on that edge.
module flash_timer #(
    parameter int FLASH_HALF    = 6_000_000,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic blank,
    output logic done
);

    // A single-cycle half-period still needs a 1-bit counter.
    localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int HW = $clog2(FLASH_TOGGLES + 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(FLASH_HALF - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(FLASH_TOGGLES - 1);

    logic [CW-1:0] cyc;
    logic [HW-1:0] half;
    logic          period_end;

    assign period_end = enable && (cyc == CYC_LAST);
    assign done       = period_end && (half == HALF_LAST);

    // Cycle/half-period counting; an even toggle count leaves blank at 0 on exit.
    always_ff @(posedge clk) begin
        if (!nRst || clear) begin
            cyc   <= '0;
            half  <= '0;
            blank <= 1'b0;
        end else if (enable) begin
            if (period_end) begin
                cyc   <= '0;
                blank <= ~blank;
                half  <= done ? '0 : half + 1'b1;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Top-level snake game sequencer: gates collisions into the score tracker,
// enables motion while playing, and flashes the frozen final score at game
// over before handing the display back to the tracker's high score.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int FLASH_HALF    = 6_000_000,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       good_in,
    input  logic       bad_in,
    input  logic [3:0] trk_bcd_ones,
    input  logic [3:0] trk_bcd_tens,
    input  logic       trk_complete,
    output logic       good_out,
    output logic       bad_out,
    output logic       run_en,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic       disp_blank,
    output logic [1:0] state_out
);

    state_t state;
    bcd_t   lat_ones, lat_tens;
    logic   complete_q;
    logic   game_over;
    logic   flash_blank, flash_done;

    // Game ends on a bad hit or on the tracker reaching maximum score. Only the
    // rising edge of trk_complete counts, so a flag left high from the previous
    // game does not end the new one at once.
    assign game_over = bad_in | (trk_complete & ~complete_q);

    flash_timer #(
        .FLASH_HALF    (FLASH_HALF),
        .FLASH_TOGGLES (FLASH_TOGGLES)
    ) u_flash (
        .clk    (clk),
        .nRst   (nRst),
        .clear  (state != FLASH),
        .enable (state == FLASH),
        .blank  (flash_blank),
        .done   (flash_done)
    );

    // State sequencing, final-score latch and trk_complete history.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state      <= IDLE;
            lat_ones   <= '0;
            lat_tens   <= '0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= trk_complete;
            case (state)
                IDLE:    if (start) state <= PLAY;
                PLAY: begin
                    if (game_over) begin
                        // Tracker still shows the pre-collision score this cycle.
                        lat_ones <= trk_bcd_ones;
                        lat_tens <= trk_bcd_tens;
                        state    <= FLASH;
                    end
                end
                FLASH:   if (flash_done) state <= HISCORE;
                HISCORE: if (start) state <= PLAY;
                default: state <= IDLE;
            endcase
        end
    end

    // Collision gating and display mux, decoded from the registered state.
    always_comb begin
        run_en     = (state == PLAY);
        good_out   = run_en & good_in & ~bad_in;
        bad_out    = run_en & bad_in;
        disp_ones  = trk_bcd_ones;
        disp_tens  = trk_bcd_tens;
        disp_blank = 1'b0;
        state_out  = state;
        if (state == FLASH) begin
            disp_ones  = lat_ones;
            disp_tens  = lat_tens;
            disp_blank = flash_blank;
        end else if (state == PLAY && trk_complete) begin
            // Restart window: tracker still shows the high score, show 00 instead.
            disp_ones = '0;
            disp_tens = '0;
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Randomized self-checking bench for game_flow_controller with a behavioural
// reference model of the game phases and a simple score tracker.
module tb_game_flow_controller;

    localparam int FH = 4;
    localparam int FT = 6;
    localparam int FLASH_LEN = FH * FT;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       start = 1'b0, good_in = 1'b0, bad_in = 1'b0, trk_complete = 1'b0;
    logic [3:0] trk_bcd_ones = '0, trk_bcd_tens = '0;
    logic       good_out, bad_out, run_en, disp_blank;
    logic [3:0] disp_ones, disp_tens;
    logic [1:0] state_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: game phase 0 idle, 1 playing, 2 flashing, 3 high score.
    int m_phase = 0;
    int m_fcnt  = 0;
    int m_score = 0;    // value the tracker model is presenting
    int m_lat   = 0;    // score frozen at game over
    bit m_prev  = 0;    // trk_complete seen last cycle

    game_flow_controller #(.FLASH_HALF(FH), .FLASH_TOGGLES(FT)) dut (
        .clk(clk), .nRst(nRst), .start(start), .good_in(good_in), .bad_in(bad_in),
        .trk_bcd_ones(trk_bcd_ones), .trk_bcd_tens(trk_bcd_tens), .trk_complete(trk_complete),
        .good_out(good_out), .bad_out(bad_out), .run_en(run_en),
        .disp_ones(disp_ones), .disp_tens(disp_tens), .disp_blank(disp_blank),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    // Advance the model by one clock using the inputs that were held over the edge.
    function automatic void model_update();
        bit playing_good;
        if (!nRst) begin
            m_phase = 0; m_fcnt = 0; m_lat = 0; m_prev = 0;
            return;
        end
        playing_good = (m_phase == 1) && good_in && !bad_in;
        case (m_phase)
            0: if (start) m_phase = 1;
            1: if (bad_in || (trk_complete && !m_prev)) begin
                   m_lat = m_score; m_phase = 2; m_fcnt = 0;
               end
            2: begin
                   m_fcnt++;
                   if (m_fcnt == FLASH_LEN) begin m_phase = 3; m_fcnt = 0; end
               end
            default: if (start) m_phase = 1;
        endcase
        if (playing_good) m_score++;
        m_prev = trk_complete;
    endfunction

    // Expected {state, run_en, good_out, bad_out, tens, ones, blank}.
    function automatic logic [13:0] exp_vec();
        int  shown;
        bit  blank, run, g, b;
        run   = (m_phase == 1);
        g     = run && good_in && !bad_in;
        b     = run && bad_in;
        blank = (m_phase == 2) ? ((m_fcnt / FH) % 2 == 1) : 1'b0;
        if (m_phase == 2)                 shown = m_lat;
        else if (run && trk_complete)     shown = 0;
        else                              shown = m_score;
        return {2'(m_phase), run, g, b, 4'(shown / 10), 4'(shown % 10), blank};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {state_out, run_en, good_out, bad_out, disp_tens, disp_ones, disp_blank};
    endfunction

    // One clock: model steps on the edge, new inputs applied on the falling edge.
    task automatic drive(input logic r, input logic st, input logic g, input logic b, input logic c);
        @(posedge clk);
        model_update();
        @(negedge clk);
        nRst = r; start = st; good_in = g; bad_in = b; trk_complete = c;
        trk_bcd_ones = 4'(m_score % 10);
        trk_bcd_tens = 4'(m_score / 10);
        #1;
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        logic [13:0] o, e;
        for (int i = 0; i < 2; i++) begin
            drive(0, rbit(), rbit(), rbit(), 0);
            drive(0, 0, 0, 0, 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e || o !== 14'h0) begin
                n_err++; $display("FAIL reset[%0d]: got %h want %h", i, o, e);
            end
        end
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_game();
        logic [13:0] o, e;
        int n;
        m_score = 0;
        drive(1, 1, 0, 0, 0);
        n = $urandom_range(3, 6);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 1, 0, 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL game_good[%0d]: got %h want %h", i, o, e); end
            drive(1, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 1, 0);
        n_cmp++;
        if (bad_out !== 1'b1 || run_en !== 1'b1) begin
            n_err++; $display("FAIL game_bad_out: got %b%b want 11", bad_out, run_en);
        end
        for (int i = 0; i <= FLASH_LEN; i++) begin
            drive(1, 0, 0, 0, 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL game_flash[%0d]: got %h want %h", i, o, e); end
        end
        n_cmp++;
        if (state_out !== 2'b11 || disp_blank !== 1'b0) begin
            n_err++; $display("FAIL game_hiscore: got %b/%b want 11/0", state_out, disp_blank);
        end
    endtask

    task automatic test_simultaneous();
        logic [13:0] o, e;
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0);
        o = obs_vec(); e = exp_vec(); n_cmp++;
        if (o !== e || good_out !== 1'b0 || bad_out !== 1'b1) begin
            n_err++; $display("FAIL simul_hit: got %h want %h", o, e);
        end
        for (int i = 0; i <= FLASH_LEN; i++) begin
            drive(1, 0, 0, 0, 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL simul_flash[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_gating();
        logic [13:0] o, e;
        int k;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, rbit(), rbit(), 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL gate_idle[%0d]: got %h want %h", i, o, e); end
        end
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        k = $urandom_range(1, FLASH_LEN - 2);
        for (int i = 0; i <= FLASH_LEN; i++) begin
            drive(1, logic'(i == k), rbit(), rbit(), 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL gate_flash[%0d]: got %h want %h", i, o, e); end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, rbit(), rbit(), 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL gate_hiscore[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_max_win();
        logic [13:0] o, e;
        drive(1, 1, 0, 0, 0);
        m_score = 49;
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 1);
        o = obs_vec(); e = exp_vec(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL win_rise: got %h want %h", o, e); end
        drive(1, 0, 0, 0, 1);
        n_cmp++;
        if (state_out !== 2'b10 || disp_tens !== 4'd5 || disp_ones !== 4'd0) begin
            n_err++; $display("FAIL win_flash_digits: got %b %0d%0d want 10 50", state_out, disp_tens, disp_ones);
        end
        for (int i = 0; i < FLASH_LEN; i++) begin
            drive(1, 0, 0, 0, 1);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL win_flash[%0d]: got %h want %h", i, o, e); end
        end
        drive(1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 1);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e || state_out !== 2'b01 || disp_tens !== 4'd0) begin
                n_err++; $display("FAIL win_restart[%0d]: got %h want %h", i, o, e);
            end
        end
        m_score = 0;
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i <= FLASH_LEN; i++) drive(1, 0, 0, 0, 0);
        n_cmp++;
        if (state_out !== 2'b11) begin n_err++; $display("FAIL win_end: got %b want 11", state_out); end
    endtask

    task automatic test_reset_midflash();
        logic [13:0] o, e;
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        o = obs_vec(); e = exp_vec(); n_cmp++;
        if (o !== e || state_out !== 2'b00 || disp_blank !== 1'b0) begin
            n_err++; $display("FAIL midflash_reset: got %h want %h", o, e);
        end
        drive(1, 1, 0, 0, 0);
        drive(1, 0, rbit(), 1, 0);
        for (int i = 0; i <= FLASH_LEN; i++) begin
            drive(1, 0, 0, 0, 0);
            o = obs_vec(); e = exp_vec(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL midflash_reflash[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_game();
        test_simultaneous();
        test_gating();
        test_max_win();
        test_reset_midflash();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Top-level game sequencer for the snake game. It gates collision events into the score tracker and enables snake motion only while a game is running. At game over it freezes the final score and flashes it on the seven-segment display for a set time, then hands the display back to the tracker, which by then shows the high score. It sits between the collision detector and the score tracker, and between the tracker and the display driver.

Parameters:
FLASH_HALF, 6_000_000, clock cycles per flash half-period (0.5 s at 12 MHz); must be ≥1
FLASH_TOGGLES, 6, number of half-periods in the flash phase; must be even and ≥2

Ports:
clk  in  1  system clock
nRst  in  1  reset, synchronous, active-low
start  in  1  one-cycle start/restart pulse from button synchroniser
good_in  in  1  raw good-collision pulse from collision detector
bad_in  in  1  raw bad-collision pulse from collision detector
trk_bcd_ones  in  4  tracker BCD ones digit
trk_bcd_tens  in  4  tracker BCD tens digit
trk_complete  in  1  tracker game-complete flag
good_out  out  1  gated good collision to tracker
bad_out  out  1  gated bad collision to tracker
run_en  out  1  snake movement enable
disp_ones  out  4  BCD ones digit to display
disp_tens  out  4  BCD tens digit to display
disp_blank  out  1  1 = display dark
state_out  out  2  current state, for debug LEDs

Behaviour:
- Reset: the clock and reset are one clock `clk`, reset `nRst`, synchronous and active-low. nRst low at a clk edge forces the following on that edge:
  - state IDLE, flash counters 0, latched digits 0, trk_complete history register 0.
  - This also applies mid-game or mid-flash; nothing else persists.
- States (state_out encoding):
  - IDLE=00: after reset only. run_en=0, good_out=bad_out=0. Display passes tracker BCD, disp_blank=0. start → PLAY.
  - PLAY=01: run_en=1.
    - good_out = good_in & ~bad_in and bad_out = bad_in, combinational, zero latency. Bad wins on simultaneous events.
    - Display passes tracker BCD, except it shows 0,0 while trk_complete=1. That case is the restart window before the first good collision, when the tracker still shows the high score.
    - Game-over trigger: bad_in=1, or a trk_complete rising edge (current=1, previous-cycle register=0), which is the maximum-score win.
    - On trigger: latch trk_bcd_tens/ones as sampled that same cycle (the score before the fatal collision), then → FLASH.
    - start is ignored in PLAY.
  - FLASH=10: run_en=0, good_out=bad_out=0, start ignored.
    - Display shows the latched digits.
    - disp_blank starts 0 and toggles every FLASH_HALF cycles.
    - After FLASH_TOGGLES half-periods (FLASH_HALF×FLASH_TOGGLES cycles from entry) → HISCORE with disp_blank=0.
  - HISCORE=11: run_en=0, collisions gated off, display passes tracker BCD, disp_blank=0. start → PLAY; flash counters cleared.
- trk_complete history register updates every cycle in every state, so a flag already high at PLAY entry does not trigger game over.
- disp_blank, latched digits and state are registered. Display mux and gating are combinational from state.

Decomposition:
- Shared package game_pkg: state enum (IDLE, PLAY, FLASH, HISCORE with the encodings above), BCD digit typedef (logic [3:0]), MAX_SCORE=50 constant shared with the score tracker.
- Sub-module flash_timer: cycle counter of width $clog2(FLASH_HALF), half-period counter and blank toggle.
  - Inputs: clk, nRst, clear, enable.
  - Outputs: blank, done (one-cycle pulse on the final half-period).

Test Plan (FLASH_HALF=4, FLASH_TOGGLES=6, behavioural tracker model):
1. Reset held 2 cycles → state_out=00, run_en=0, good_out=bad_out=0, disp_blank=0, display 0,0.
2. start; three good_in pulses (tracker 0,3); bad_in → bad_out=1 same cycle; next cycle state=10 showing 0,3. disp_blank: 0 for 4, 1 for 4 cycles, repeated 3 times (24 cycles), then state=11 showing tracker high score, blank=0.
3. PLAY, good_in=bad_in=1 same cycle → good_out=0, bad_out=1, FLASH entered.
4. good_in/bad_in in IDLE, FLASH, HISCORE → outputs stay 0; start pulse during FLASH → no state change, flash runs to completion.
5. PLAY, trk_complete rises with tracker 5,0 → FLASH shows 5,0. Then start from HISCORE with trk_complete still 1 → PLAY, display 0,0, no immediate game over.
6. nRst low at cycle 10 of FLASH → next edge state=00, disp_blank=0; a subsequent start gives a full-length flash on the next game over.
